spi_job_host: RTL and testbench

SPI_JOB_HOST -- requirements
Module: spi_job_host

---
 rtl/spi_job_host_pkg.sv | 15 +
 rtl/spi_host_shifter.sv | 86 ++++++++
 rtl/spi_job_host.sv | 136 +++++++++++++
 tb/tb_spi_job_host.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_job_host_pkg.sv
// Shared definitions for the SPI job host: FSM states and SPI mode constants.
package spi_job_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        READ,
        HOLD
    } state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_host_shifter.sv
// SPI mode-0 master shifter: one CS-framed transfer of WIDTH bits per start pulse.
// Transfer spans (2*WIDTH+2)*SCK_HALF cycles with CS low; start is ignored while active.
module spi_host_shifter
    import spi_job_host_pkg::*;
#(
    parameter int WIDTH    = 352,
    parameter int SCK_HALF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             sdi,
    output logic             sck,
    output logic             sdo,
    output logic             cs_n,
    output logic [WIDTH-1:0] rx_data,
    output logic             done
);

    localparam int                    CNT_BITS     = $clog2(WIDTH + 1);
    localparam logic [7:0]            DIV_LAST     = 8'(SCK_HALF - 1);
    localparam logic [CNT_BITS-1:0]   LAST_BIT     = CNT_BITS'(WIDTH);
    localparam logic                  SCK_IDLE     = SPI_CPOL;
    localparam logic                  CAPTURE_LEAD = !SPI_CPHA;

    logic                active;
    logic                lead;
    logic [7:0]          div;
    logic [CNT_BITS-1:0] bit_cnt;
    logic [WIDTH-1:0]    tx_shift;
    logic                tick;

    assign tick = (div == DIV_LAST);

    // Half-period phases: one lead-in, two per bit, one trailing low before CS rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            lead     <= 1'b0;
            div      <= 8'd0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_data  <= '0;
            sck      <= SCK_IDLE;
            sdo      <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (start) begin
                    active   <= 1'b1;
                    lead     <= 1'b1;
                    cs_n     <= 1'b0;
                    div      <= 8'd0;
                    bit_cnt  <= '0;
                    tx_shift <= tx_data;
                    sdo      <= tx_data[WIDTH-1];
                end
            end else begin
                div <= tick ? 8'd0 : div + 8'd1;
                if (tick) begin
                    if (lead) begin
                        lead <= 1'b0;
                    end else if (sck != SCK_IDLE) begin
                        sck      <= SCK_IDLE;
                        bit_cnt  <= bit_cnt + CNT_BITS'(1);
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        sdo      <= tx_shift[WIDTH-2];
                    end else if (bit_cnt == LAST_BIT) begin
                        active <= 1'b0;
                        cs_n   <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        sck <= ~SCK_IDLE;
                        if (CAPTURE_LEAD) begin
                            rx_data <= {rx_data[WIDTH-2:0], sdi};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spi_job_host.sv
// Broadcasts a job word on the global SPI bus, waits for READY, reads the daisy-chain result.
// Jobs wait on job_valid_in until IDLE; the result is held in HOLD until result_ready_in.
module spi_job_host
    import spi_job_host_pkg::*;
#(
    parameter int JOB_BITS    = 352,
    parameter int RESULT_BITS = 40,
    parameter int SCK_HALF    = 4
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic [JOB_BITS-1:0]    job_data_in,
    input  logic                   job_valid_in,
    output logic                   job_ready_out,
    output logic                   sck0_out,
    output logic                   sdo0_out,
    output logic                   cs0_n_out,
    output logic                   sck1_out,
    output logic                   sdo1_out,
    input  logic                   sdi1_in,
    output logic                   cs1_n_out,
    input  logic                   ready_n_in,
    input  logic                   abort_in,
    output logic [RESULT_BITS-1:0] result_data_out,
    output logic                   result_valid_out,
    input  logic                   result_ready_in,
    output logic                   busy_out
);

    state_t                 state;
    logic                   sync1;
    logic                   sync2;
    logic                   load_start;
    logic                   load_done;
    logic                   read_start;
    logic                   read_done;
    logic [RESULT_BITS-1:0] read_word;

    // job_ready_out is registered, so the first accept lands on the second edge after reset.
    assign load_start = job_valid_in && job_ready_out;
    assign read_start = (state == WAIT) && !abort_in && !sync2;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ready_n_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state            <= IDLE;
            job_ready_out    <= 1'b0;
            busy_out         <= 1'b0;
            result_valid_out <= 1'b0;
            result_data_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state         <= LOAD;
                        job_ready_out <= 1'b0;
                        busy_out      <= 1'b1;
                    end else begin
                        job_ready_out <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_done) state <= WAIT;
                end
                WAIT: begin
                    if (abort_in) begin
                        state         <= IDLE;
                        job_ready_out <= 1'b1;
                        busy_out      <= 1'b0;
                    end else if (!sync2) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (read_done) begin
                        state            <= HOLD;
                        result_data_out  <= read_word;
                        result_valid_out <= 1'b1;
                    end
                end
                HOLD: begin
                    if (result_ready_in) begin
                        state            <= IDLE;
                        result_valid_out <= 1'b0;
                        job_ready_out    <= 1'b1;
                        busy_out         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    spi_host_shifter #(
        .WIDTH    (JOB_BITS),
        .SCK_HALF (SCK_HALF)
    ) u_global (
        .clk     (clk_in),
        .rst_n   (reset_n_in),
        .start   (load_start),
        .tx_data (job_data_in),
        .sdi     (1'b0),
        .sck     (sck0_out),
        .sdo     (sdo0_out),
        .cs_n    (cs0_n_out),
        .rx_data (),
        .done    (load_done)
    );

    // Daisy bus only reads: MOSI shifts out zeros.
    spi_host_shifter #(
        .WIDTH    (RESULT_BITS),
        .SCK_HALF (SCK_HALF)
    ) u_daisy (
        .clk     (clk_in),
        .rst_n   (reset_n_in),
        .start   (read_start),
        .tx_data ('0),
        .sdi     (sdi1_in),
        .sck     (sck1_out),
        .sdo     (sdo1_out),
        .cs_n    (cs1_n_out),
        .rx_data (read_word),
        .done    (read_done)
    );

endmodule

// File: tb/tb_spi_job_host.sv
// Directed scenarios for spi_job_host with a job/result scoreboard; DUT b runs SCK_HALF=1.
module tb_spi_job_host;

    localparam int JB = 352;
    localparam int RB = 40;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic [JB-1:0] job_data = '0;
    logic          job_valid = 1'b0;
    logic          job_ready, sck0, sdo0, cs0_n, sck1, sdo1, cs1_n, result_valid, busy;
    logic          sdi1 = 1'b0;
    logic          ready_n = 1'b1;
    logic          abort = 1'b0;
    logic          result_ready = 1'b0;
    logic [RB-1:0] result_data;

    logic [JB-1:0] b_job_data = '0;
    logic          b_job_valid = 1'b0;
    logic          b_job_ready, b_sck0, b_sdo0, b_cs0_n, b_sck1, b_sdo1, b_cs1_n, b_result_valid, b_busy;
    logic          b_sdi1 = 1'b0;
    logic          b_ready_n = 1'b1;
    logic          b_abort = 1'b0;
    logic          b_result_ready = 1'b0;
    logic [RB-1:0] b_result_data;

    int tests = 0;
    int fails = 0;
    logic [JB-1:0] job_q[$];
    logic [RB-1:0] res_q[$];
    logic [RB-1:0] held_exp = '0;

    always #5 clk = ~clk;

    spi_job_host #(.JOB_BITS(JB), .RESULT_BITS(RB), .SCK_HALF(4)) dut (
        .clk_in(clk), .reset_n_in(reset_n), .job_data_in(job_data), .job_valid_in(job_valid),
        .job_ready_out(job_ready), .sck0_out(sck0), .sdo0_out(sdo0), .cs0_n_out(cs0_n),
        .sck1_out(sck1), .sdo1_out(sdo1), .sdi1_in(sdi1), .cs1_n_out(cs1_n),
        .ready_n_in(ready_n), .abort_in(abort), .result_data_out(result_data),
        .result_valid_out(result_valid), .result_ready_in(result_ready), .busy_out(busy)
    );

    spi_job_host #(.JOB_BITS(JB), .RESULT_BITS(RB), .SCK_HALF(1)) dut_b (
        .clk_in(clk), .reset_n_in(reset_n), .job_data_in(b_job_data), .job_valid_in(b_job_valid),
        .job_ready_out(b_job_ready), .sck0_out(b_sck0), .sdo0_out(b_sdo0), .cs0_n_out(b_cs0_n),
        .sck1_out(b_sck1), .sdo1_out(b_sdo1), .sdi1_in(b_sdi1), .cs1_n_out(b_cs1_n),
        .ready_n_in(b_ready_n), .abort_in(b_abort), .result_data_out(b_result_data),
        .result_valid_out(b_result_valid), .result_ready_in(b_result_ready), .busy_out(b_busy)
    );

    function automatic logic [JB-1:0] rand_job();
        logic [JB-1:0] r;
        for (int i = 0; i < JB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Records one global-bus transfer of DUT a as seen by a mode-0 slave.
    task automatic capture_a(output logic [JB-1:0] bits, output int rises, output int low_cyc,
                             output bit timed_out);
        logic prev;
        bit   started;
        bits = '0; rises = 0; low_cyc = 0; timed_out = 1'b1; prev = 1'b0; started = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (cs0_n === 1'b0) begin
                if (!started) job_valid = 1'b0;
                started = 1'b1;
                low_cyc++;
                if (sck0 && !prev) begin
                    rises++;
                    bits = {bits[JB-2:0], sdo0};
                end
            end else if (started) begin
                timed_out = 1'b0;
                break;
            end
            prev = sck0;
        end
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if ({cs0_n, cs1_n, sck0, sck1, sdo0, sdo1, job_ready, result_valid, busy} !== 9'b110000000) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 110000000",
                     {cs0_n, cs1_n, sck0, sck1, sdo0, sdo1, job_ready, result_valid, busy});
        end
        tests++;
        if (result_data !== '0) begin
            fails++; $display("FAIL reset_result: got %h want 0", result_data);
        end
        tests++;
        if ({b_cs0_n, b_cs1_n, b_job_ready, b_busy} !== 4'b1100) begin
            fails++; $display("FAIL reset_b: got %b want 1100", {b_cs0_n, b_cs1_n, b_job_ready, b_busy});
        end
        job_data = {44{8'hA5}};
        job_valid = 1'b1;
        job_q.push_back(job_data);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (job_ready !== 1'b1) begin
            fails++; $display("FAIL release_ready: got %b want 1", job_ready);
        end
        tests++;
        if (cs0_n !== 1'b1) begin
            fails++; $display("FAIL release_early_accept: cs0_n got %b want 1", cs0_n);
        end
        @(posedge clk); #1;
        tests++;
        if (cs0_n !== 1'b0) begin
            fails++; $display("FAIL first_accept: cs0_n got %b want 0", cs0_n);
        end
    endtask

    task automatic test_load;
        logic [JB-1:0] bits, exp;
        int rises, low;
        bit to, bad;
        capture_a(bits, rises, low, to);
        exp = (job_q.size() > 0) ? job_q.pop_front() : '0;
        tests++;
        if (to) begin fails++; $display("FAIL load_timeout: cs0_n did not complete a transfer"); end
        tests++;
        if (bits !== exp) begin fails++; $display("FAIL load_bits: got %h want %h", bits, exp); end
        tests++;
        if (rises !== 352) begin fails++; $display("FAIL load_sck_pulses: got %0d want 352", rises); end
        tests++;
        if (low !== 2824) begin fails++; $display("FAIL load_cs_cycles: got %0d want 2824", low); end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cs1_n !== 1'b1 || busy !== 1'b1 || job_ready !== 1'b0 || cs0_n !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL wait_park: got cs1_n=%b busy=%b want 1 1", cs1_n, busy); end
    endtask

    task automatic test_read;
        logic [RB-1:0] val, exp;
        int lat, falls;
        bit to, bad_sdo, bad_cs0, bad_hold;
        logic prev;
        val = 40'h12_3456_789A;
        res_q.push_back(val);
        @(posedge clk); #1 ready_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (cs1_n === 1'b0) begin lat = k; break; end
        end
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL read_latency: got %0d want 3", lat); end
        ready_n = 1'b1;
        sdi1 = val[RB-1];
        falls = 0; prev = 1'b0; to = 1'b1; bad_sdo = 1'b0; bad_cs0 = 1'b0; bad_hold = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin to = 1'b0; break; end
            if (sdo1 !== 1'b0) bad_sdo = 1'b1;
            if (cs1_n === 1'b0 && cs0_n !== 1'b1) bad_cs0 = 1'b1;
            if (result_data !== '0) bad_hold = 1'b1;
            if (prev && !sck1) begin
                falls++;
                sdi1 = (falls < RB) ? val[RB-1-falls] : 1'b0;
            end
            prev = sck1;
        end
        exp = (res_q.size() > 0) ? res_q.pop_front() : '0;
        held_exp = exp;
        tests++;
        if (to) begin fails++; $display("FAIL read_timeout: result_valid never rose"); end
        tests++;
        if (result_data !== exp) begin fails++; $display("FAIL read_result: got %h want %h", result_data, exp); end
        tests++;
        if (bad_sdo) begin fails++; $display("FAIL read_sdo1: saw nonzero sdo1 want 0"); end
        tests++;
        if (bad_cs0) begin fails++; $display("FAIL cs_overlap: cs0_n low during read want high"); end
        tests++;
        if (bad_hold) begin fails++; $display("FAIL read_prev_result: result changed mid-read want 0"); end
    endtask

    task automatic test_hold;
        logic [JB-1:0] exp2, bits, exp;
        int rises, low;
        bit to, bad_stable, bad_acc;
        exp2 = rand_job();
        @(negedge clk);
        job_data = exp2; job_valid = 1'b1; job_q.push_back(exp2);
        bad_stable = 1'b0; bad_acc = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            abort = (c == 10);
            if (result_valid !== 1'b1 || result_data !== held_exp) bad_stable = 1'b1;
            if (job_ready !== 1'b0 || cs0_n !== 1'b1) bad_acc = 1'b1;
        end
        abort = 1'b0;
        tests++;
        if (bad_stable) begin fails++; $display("FAIL hold_stable: got %b/%h want 1/%h", result_valid, result_data, held_exp); end
        tests++;
        if (bad_acc) begin fails++; $display("FAIL hold_early_accept: job accepted during HOLD"); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({result_valid, job_ready} !== 2'b01) begin
            fails++; $display("FAIL handshake: got valid,ready=%b want 01", {result_valid, job_ready});
        end
        @(negedge clk) result_ready = 1'b0;
        capture_a(bits, rises, low, to);
        exp = (job_q.size() > 0) ? job_q.pop_front() : '0;
        tests++;
        if (to || bits !== exp || rises !== 352) begin
            fails++; $display("FAIL pending_job: got %h (%0d bits) want %h", bits, rises, exp);
        end
    endtask

    task automatic test_abort;
        bit bad;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 ready_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy, job_ready, cs1_n} !== 3'b011) begin
            fails++; $display("FAIL abort_idle: got busy,ready,cs1_n=%b want 011", {busy, job_ready, cs1_n});
        end
        abort = 1'b0; ready_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cs1_n !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL abort_no_read: got cs1_n=%b busy=%b want 1 0", cs1_n, busy); end
    endtask

    task automatic test_reset_mid;
        logic [JB-1:0] bits, exp;
        int rises, low;
        bit to;
        logic prev;
        @(negedge clk);
        job_data = rand_job(); job_valid = 1'b1;
        rises = 0; prev = 1'b0; to = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (cs0_n === 1'b0) job_valid = 1'b0;
            if (sck0 && !prev) rises++;
            prev = sck0;
            if (rises == 100) begin to = 1'b0; break; end
        end
        tests++;
        if (to) begin fails++; $display("FAIL midreset_reach: got %0d rises want 100", rises); end
        #1 reset_n = 1'b0;
        #1;
        tests++;
        if (cs0_n !== 1'b1) begin fails++; $display("FAIL midreset_cs0: got %b want 1", cs0_n); end
        tests++;
        if ({sck0, sdo0, busy, job_ready} !== 4'b0000) begin
            fails++; $display("FAIL midreset_outputs: got %b want 0000", {sck0, sdo0, busy, job_ready});
        end
        job_valid = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        exp = rand_job();
        job_data = exp; job_valid = 1'b1; job_q.push_back(exp);
        capture_a(bits, rises, low, to);
        exp = (job_q.size() > 0) ? job_q.pop_front() : '0;
        tests++;
        if (to || bits !== exp) begin fails++; $display("FAIL postreset_bits: got %h want %h", bits, exp); end
        tests++;
        if (rises !== 352 || low !== 2824) begin
            fails++; $display("FAIL postreset_frame: got %0d pulses %0d cycles want 352 2824", rises, low);
        end
    endtask

    task automatic test_fast;
        logic [JB-1:0] bits, exp;
        int rises, low, last;
        bit to, started, bad_period, bad;
        logic prev;
        @(negedge clk) b_ready_n = 1'b0;
        @(negedge clk) b_ready_n = 1'b1;
        exp = rand_job();
        b_job_data = exp; b_job_valid = 1'b1; job_q.push_back(exp);
        bits = '0; rises = 0; low = 0; last = 0; to = 1'b1; started = 1'b0; bad_period = 1'b0; prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (b_cs0_n === 1'b0) begin
                if (!started) b_job_valid = 1'b0;
                started = 1'b1;
                low++;
                if (low == 100) b_ready_n = 1'b0;
                if (low == 101) b_ready_n = 1'b1;
                if (b_sck0 && !prev) begin
                    if (rises > 0 && c - last != 2) bad_period = 1'b1;
                    last = c;
                    rises++;
                    bits = {bits[JB-2:0], b_sdo0};
                end
            end else if (started) begin
                to = 1'b0;
                break;
            end
            prev = b_sck0;
        end
        exp = (job_q.size() > 0) ? job_q.pop_front() : '0;
        tests++;
        if (to || bits !== exp) begin fails++; $display("FAIL fast_bits: got %h want %h", bits, exp); end
        tests++;
        if (rises !== 352 || low !== 706) begin
            fails++; $display("FAIL fast_frame: got %0d pulses %0d cycles want 352 706", rises, low);
        end
        tests++;
        if (bad_period) begin fails++; $display("FAIL fast_sck_period: saw period other than 2 cycles"); end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (b_cs1_n !== 1'b1 || b_busy !== 1'b1) bad = 1'b1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL fast_glitch: got cs1_n=%b busy=%b want 1 1", b_cs1_n, b_busy); end
        @(negedge clk) b_abort = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({b_busy, b_job_ready} !== 2'b01) begin
            fails++; $display("FAIL fast_abort: got busy,ready=%b want 01", {b_busy, b_job_ready});
        end
        b_abort = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load;
        test_read;
        test_hold;
        test_abort;
        test_reset_mid;
        test_fast;
        tests++;
        if (job_q.size() != 0 || res_q.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", job_q.size(), res_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
